// File: rtl/md5_brute_pkg.sv
// Shared constants and state encodings for the MD5 brute-force slice.
// Pipeline latency lives here so the driver, the pipelines and the hit capture agree.
package md5_brute_pkg;

    localparam int unsigned COUNT_W      = 29;
    localparam int unsigned LANES        = 8;
    localparam int unsigned LANE_W       = 3;
    localparam int unsigned PIPE_LATENCY = 66;

    typedef enum logic [2:0] {
        ST_FILL  = 3'b001,
        ST_ARMED = 3'b010,
        ST_HIT   = 3'b100
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/md5_hit_capture_delay_line.sv
// Free-running shift register: o_data is i_data as sampled DEPTH edges earlier.
// Only the registers' async clear is reset; there is no data-path flush.
module delay_line #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 66
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/md5_hit_capture.sv
// Recovers the winning candidate from the MD5 pipelines: delays the shared counter by
// the pipeline latency, latches the first hit with its lane, counts repeats, drives the display.
module md5_hit_capture #(
    parameter int unsigned COUNT_W = md5_brute_pkg::COUNT_W,
    parameter int unsigned LANES   = md5_brute_pkg::LANES,
    parameter int unsigned LANE_W  = md5_brute_pkg::LANE_W,
    parameter int unsigned LATENCY = md5_brute_pkg::PIPE_LATENCY
) (
    input  logic                      CLK,
    input  logic                      CPU_RESETN,
    input  logic [COUNT_W-1:0]        count_in,
    input  logic [LANES-1:0]          found_in,
    input  logic                      clear,
    output logic                      armed,
    output logic                      hit_valid,
    output logic [COUNT_W+LANE_W-1:0] hit_candidate,
    output logic [LANE_W-1:0]         hit_lane,
    output logic                      multi_hit,
    output logic [7:0]                hit_count,
    output logic [COUNT_W+LANE_W-1:0] display_value
);

    import md5_brute_pkg::*;

    localparam int unsigned FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);

    state_t                      r_state;
    logic [FILL_W-1:0]           r_fill;
    logic                        r_armed;
    logic                        r_hit_valid;
    logic [COUNT_W+LANE_W-1:0]   r_cand;
    logic [LANE_W-1:0]           r_lane;
    logic                        r_multi;
    logic [7:0]                  r_count;

    logic [COUNT_W-1:0]          w_delay_out;
    logic                        w_any;
    logic                        w_multi;
    logic [LANE_W-1:0]           w_lane;

    delay_line #(
        .WIDTH (COUNT_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .i_clk   (CLK),
        .i_rst_n (CPU_RESETN),
        .i_data  (count_in),
        .o_data  (w_delay_out)
    );

    assign w_any   = |found_in;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(found_in & (found_in - LANES'(1)));

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        w_lane = '0;
        for (int unsigned i = LANES; i > 0; i--) begin
            if (found_in[i-1]) w_lane = LANE_W'(i - 1);
        end
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state     <= ST_FILL;
            r_fill      <= '0;
            r_armed     <= 1'b0;
            r_hit_valid <= 1'b0;
            r_cand      <= '0;
            r_lane      <= '0;
            r_multi     <= 1'b0;
            r_count     <= '0;
        end else if (clear) begin
            r_state     <= ST_FILL;
            r_fill      <= '0;
            r_armed     <= 1'b0;
            r_hit_valid <= 1'b0;
            r_cand      <= '0;
            r_lane      <= '0;
            r_multi     <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (r_fill == FILL_LAST) begin
                        r_state <= ST_ARMED;
                        r_armed <= 1'b1;
                    end else begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_any) begin
                        r_state     <= ST_HIT;
                        r_hit_valid <= 1'b1;
                        r_cand      <= {w_delay_out, w_lane};
                        r_lane      <= w_lane;
                        r_multi     <= w_multi;
                    end
                end
                ST_HIT: begin
                    if (w_any) r_count <= sat_inc8(r_count);
                end
                default: begin
                    r_state <= ST_FILL;
                    r_fill  <= '0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign armed         = r_armed;
    assign hit_valid     = r_hit_valid;
    assign hit_candidate = r_cand;
    assign hit_lane      = r_lane;
    assign multi_hit     = r_multi;
    assign hit_count     = r_count;
    assign display_value = r_hit_valid ? r_cand : {count_in, {LANE_W{1'b0}}};

endmodule

// File: tb/tb_md5_hit_capture.sv
// Directed bench for md5_hit_capture: scoreboard of expected captures built from the
// bench's own record of sampled counter values.
module tb_md5_hit_capture;

    logic        CLK = 1'b0;
    logic        CPU_RESETN;
    logic [28:0] count_in;
    logic [7:0]  found_in;
    logic        clear;
    logic        armed;
    logic        hit_valid;
    logic [31:0] hit_candidate;
    logic [2:0]  hit_lane;
    logic        multi_hit;
    logic [7:0]  hit_count;
    logic [31:0] display_value;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int ce;

    logic [28:0] hist [0:2047];
    logic [31:0] exp_cand_q [$];
    logic        exp_multi_q [$];

    md5_hit_capture #(
        .COUNT_W (29),
        .LANES   (8),
        .LANE_W  (3),
        .LATENCY (66)
    ) dut (
        .CLK           (CLK),
        .CPU_RESETN    (CPU_RESETN),
        .count_in      (count_in),
        .found_in      (found_in),
        .clear         (clear),
        .armed         (armed),
        .hit_valid     (hit_valid),
        .hit_candidate (hit_candidate),
        .hit_lane      (hit_lane),
        .multi_hit     (multi_hit),
        .hit_count     (hit_count),
        .display_value (display_value)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter ramps so that edge e samples count_in == e.
    task automatic tick();
        count_in = 29'(edge_n + 1);
        @(posedge CLK);
        edge_n++;
        hist[edge_n] = count_in;
        #1;
    endtask

    function automatic logic [2:0] low_lane(input logic [7:0] f);
        logic [2:0] l;
        logic [7:0] v;
        l = 3'd0;
        v = f;
        if (v != 8'h00) begin
            while (!v[0]) begin
                v = v >> 1;
                l = l + 3'd1;
            end
        end
        return l;
    endfunction

    // Drives one found pulse on the next edge and records what it should capture.
    task automatic drive_hit(input logic [7:0] f);
        logic [28:0] delayed;
        delayed = hist[edge_n + 1 - 66];
        exp_cand_q.push_back({delayed, low_lane(f)});
        exp_multi_q.push_back($countones(f) >= 2);
        found_in = f;
        tick();
        found_in = 8'h00;
    endtask

    task automatic capture_check(input string tag);
        logic [31:0] ec;
        logic        em;
        ec = exp_cand_q.pop_front();
        em = exp_multi_q.pop_front();
        check({tag, "_valid"}, hit_valid, 32'd1);
        check({tag, "_cand"},  hit_candidate, ec);
        check({tag, "_lane"},  hit_lane, ec[2:0]);
        check({tag, "_multi"}, multi_hit, em);
        check({tag, "_disp"},  display_value, ec);
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        clear      = 1'b0;
        found_in   = 8'h00;
        count_in   = 29'h0ABCDEF;
        #12;
        check("rst_armed", armed, 32'd0);
        check("rst_valid", hit_valid, 32'd0);
        check("rst_cand",  hit_candidate, 32'd0);
        check("rst_lane",  hit_lane, 32'd0);
        check("rst_multi", multi_hit, 32'd0);
        check("rst_count", hit_count, 32'd0);
        check("rst_disp",  display_value, {29'h0ABCDEF, 3'b000});

        @(posedge CLK);
        #1;
        CPU_RESETN = 1'b1;
        edge_n = 0;

        // Early found during FILL is dropped and never deferred.
        while (edge_n < 9) tick();
        found_in = 8'hFF;
        tick();
        found_in = 8'h00;
        check("early_valid", hit_valid, 32'd0);
        while (edge_n < 65) tick();
        check("fill_armed_low", armed, 32'd0);
        tick();
        check("fill_armed_high", armed, 32'd1);
        check("early_no_capture", hit_valid, 32'd0);

        // Fill and capture at edge 100.
        while (edge_n < 99) tick();
        drive_hit(8'h04);
        capture_check("cap1");
        check("cap1_const", hit_candidate, 32'd274);
        check("cap1_count", hit_count, 32'd0);

        // Repeat hits and saturation.
        found_in = 8'h01;
        for (int i = 0; i < 10; i++) tick();
        check("rep_count10", hit_count, 32'd10);
        for (int i = 0; i < 290; i++) tick();
        found_in = 8'h00;
        check("rep_sat", hit_count, 32'd255);
        check("rep_cand_frozen", hit_candidate, 32'd274);
        check("rep_lane_frozen", hit_lane, 32'd2);
        tick();
        check("rep_sat_hold", hit_count, 32'd255);

        // Clear from HIT, refill, capture in the first armed cycle with multi-hit.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", hit_valid, 32'd0);
        check("clr_armed", armed, 32'd0);
        check("clr_count", hit_count, 32'd0);
        check("clr_cand",  hit_candidate, 32'd0);
        check("clr_disp",  display_value, {count_in, 3'b000});
        ce = edge_n;
        while (edge_n < ce + 65) tick();
        check("refill_armed_low", armed, 32'd0);
        tick();
        check("refill_armed_high", armed, 32'd1);
        drive_hit(8'hA0);
        capture_check("cap2");

        // Clear and found on the same edge while ARMED: clear wins.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ce = edge_n;
        while (edge_n < ce + 66) tick();
        check("pre_prio_armed", armed, 32'd1);
        check("pre_prio_valid", hit_valid, 32'd0);
        clear    = 1'b1;
        found_in = 8'h01;
        tick();
        clear    = 1'b0;
        found_in = 8'h00;
        check("prio_valid", hit_valid, 32'd0);
        check("prio_armed", armed, 32'd0);
        ce = edge_n;
        while (edge_n < ce + 65) tick();
        check("prio_armed_low", armed, 32'd0);
        check("prio_valid_low", hit_valid, 32'd0);
        tick();
        check("prio_armed_high", armed, 32'd1);

        // Async reset mid-cycle in HIT, then display mux.
        drive_hit(8'h01);
        capture_check("cap3");
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("arst_armed", armed, 32'd0);
        check("arst_valid", hit_valid, 32'd0);
        check("arst_cand",  hit_candidate, 32'd0);
        check("arst_lane",  hit_lane, 32'd0);
        check("arst_multi", multi_hit, 32'd0);
        count_in = 29'h1FFFFFFF;
        #1;
        check("arst_disp", display_value, 32'hFFFFFFF8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md5_hit_capture.md
# md5_hit_capture

Downstream companion to the brute-force driver. Sits between the eight MD5 comparison pipelines and the 7-segment display. It recovers which 32-bit candidate produced a `found` pulse by delaying the shared 29-bit counter value by the pipeline latency and encoding the winning lane. It latches the first hit, counts repeat hits, and selects what the display shows.

## Interface
Parameters:
- `COUNT_W`, 29: width of the shared candidate counter.
- `LANES`, 8: number of parallel pipelines; must be a power of two.
- `LANE_W`, 3: log2(`LANES`).
- `LATENCY`, 66: cycles from `count_in` sampled to the matching `found_in` bit; must be at least 1.

Ports:
- `CLK`  in  1: system clock. All logic is on the rising edge.
- `CPU_RESETN`  in  1: reset. Asynchronous assert, active-low.
- `count_in`  in  `COUNT_W`: live counter value, the same value feeding every pipeline.
- `found_in`  in  `LANES`: per-lane match flags. Bit i corresponds to candidate `{count, i[LANE_W-1:0]}`.
- `clear`  in  1: synchronous re-arm. Drops the hit and restarts the fill.
- `armed`  out  1: the delay line is full and hits are accepted.
- `hit_valid`  out  1: a candidate has been latched.
- `hit_candidate`  out  `COUNT_W+LANE_W`: the latched candidate, `{delayed_count, lane}`.
- `hit_lane`  out  `LANE_W`: the winning lane index.
- `multi_hit`  out  1: more than one `found_in` bit was set in the capture cycle.
- `hit_count`  out  8: number of cycles with any `found_in` bit set while in HIT, saturating at 255.
- `display_value`  out  `COUNT_W+LANE_W`: `hit_candidate` when `hit_valid`, else `{count_in, LANE_W'b0}`.

## Operation
- **Delay line.** `LATENCY`-deep shift register of `count_in`. It shifts every cycle, unconditionally: pipelines are free-running, so a paused counter re-hashes the same value and the line must track it.
- **State machine.** States FILL, ARMED, HIT; one-hot encoded.
  - FILL: fill counter runs 0 .. `LATENCY`-1. `found_in` is ignored. When the counter reaches `LATENCY`-1, go to ARMED.
  - ARMED: if any `found_in` bit is set, latch `{delay_out, lane}` and go to HIT.
  - HIT: terminal state. Latched fields are frozen. `hit_count` increments on every cycle with any `found_in` bit set, saturating at 255.
- **Lane encoding.** Priority goes to the lowest set bit of `found_in`. `multi_hit` is set if the popcount of `found_in` is at least 2 in the capture cycle.
- **Clear.**
  - `clear` in any state returns to FILL with the fill counter at 0.
  - It zeroes `hit_valid`, `hit_candidate`, `hit_lane`, `multi_hit` and `hit_count`.
  - The delay line is not flushed.
  - `clear` has priority over a simultaneous `found_in`.
- **Reset values.** On `CPU_RESETN` low, all outputs are 0 except `display_value`, which follows `count_in` combinationally. The state is FILL, the fill counter is 0, and delay line contents are 0.

## Timing
- `found_in` sampled high at edge t belongs to the `count_in` sampled at edge t-`LATENCY`.
- On that edge, `hit_valid`, `hit_candidate`, `hit_lane` and `multi_hit` update. They are visible in cycle t+1.
- `armed` rises exactly `LATENCY` edges after reset release or after the edge that samples `clear`.
- A `found_in` in the same cycle that `armed` first goes high is captured.
- `found_in` in FILL is dropped silently. There is no deferred capture.
- `display_value` is combinational from registers and `count_in`. There is no extra latency.
- Counter wrap: the delayed value wraps naturally. There is no special handling, and a candidate of 0 is legal.
- Reset mid-HIT: all latched state is lost immediately, asynchronously.

## Structure
- Shared package `md5_brute_pkg` holds:
  - `COUNT_W`, `LANES`, `LANE_W`, `PIPE_LATENCY`;
  - the state encodings `ST_FILL`, `ST_ARMED`, `ST_HIT`.
  
  The driver and the pipelines take the latency from this package so the value cannot drift.
- One sub-module, `delay_line`, parameterised by width and depth. It is a plain shift register with no reset on the data path, apart from the async clear of the registers.
- The priority encoder and popcount-of-2 detection are local combinational logic.

## Test plan
1. **Fill and capture.** Release reset, ramp `count_in` +1 per cycle from 0. Pulse `found_in`=8'h04 at edge 100. Expect `armed` high after 66 edges, `hit_valid`=1, `hit_lane`=2, `hit_candidate`={29'd34, 3'd2}=32'd274.
2. **Multi-hit priority.** While ARMED, `found_in`=8'hA0. Expect `hit_lane`=5 and `multi_hit`=1.
3. **Repeat hits and saturation.** In HIT, hold `found_in`=8'h01 for 300 cycles. Expect `hit_count` to stop at 255 and `hit_candidate` to stay unchanged.
4. **Early found ignored.** Pulse `found_in`=8'hFF at edge 10 after reset. Expect `hit_valid`=0, with no capture once `armed` rises later.
5. **Clear priority.** Assert `clear` and `found_in`=8'h01 on the same edge in ARMED. Expect FILL, `hit_valid`=0, and `armed` low for 66 cycles.
6. **Async reset and display mux.** Assert `CPU_RESETN` low mid-clock in HIT. Expect all outputs 0 immediately. With `count_in`=29'h1FFFFFFF, expect `display_value`=32'hFFFFFFF8.
